// File: rtl/odpc_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : odpc_pkg                                                      |
// | Brief  : Shared types and constants for the ODPC LBP range decoder:   |
// |          decoder FSM state type, default LBP word width and the bit   |
// |          positions of the fault-monitor flag bus.                     |
// | Rev    : 1.0 - initial release                                         |
// +------------------------------------------------------------------------+
package odpc_pkg;

  localparam int LBP_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  // Fault-monitor flag bus layout
  localparam int FLAG_HI_BIT  = 0;
  localparam int FLAG_LO_BIT  = 1;
  localparam int FLAG_INV_BIT = 2;
  localparam int FLAG_W       = 3;

endpackage
`default_nettype wire

// File: rtl/lbp_bit_resolver.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : lbp_bit_resolver                                              |
// | Brief  : Resolve latch for one bound. The first scanned bit where the |
// |          LBP pattern is 1 is the first bit where x differs from the   |
// |          bound; x's bit there decides the direction.                  |
// | Ports  : clk, rst_n        - clock, async active-low reset            |
// |          clear             - start of a new triple (sync clear)       |
// |          scan_en           - a scan cycle is in progress              |
// |          lbp_bit, x_bit    - current scanned bits                     |
// |          resolved, dir     - state including this cycle's decision   |
// | Rev    : 1.0 - initial release                                         |
// +------------------------------------------------------------------------+
module lbp_bit_resolver
  import odpc_pkg::*;
#(
  parameter bit INVERT = 1'b0  // 1: dir = ~x_bit (x below bound)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic scan_en,
  input  logic lbp_bit,
  input  logic x_bit,
  output logic resolved,
  output logic dir
);

  logic resolved_q, resolved_d;
  logic dir_q, dir_d;
  logic hit;
  logic hit_dir;

  always_comb begin
    hit        = scan_en && !resolved_q && lbp_bit;
    hit_dir    = x_bit ^ INVERT;
    resolved_d = resolved_q;
    dir_d      = dir_q;
    if (clear) begin
      resolved_d = 1'b0;
      dir_d      = 1'b0;
    end else if (hit) begin
      resolved_d = 1'b1;
      dir_d      = hit_dir;
    end
    // Look-through view so the FSM can exit on the resolving cycle itself
    resolved = resolved_q || hit;
    dir      = hit ? hit_dir : dir_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resolved_q <= 1'b0;
      dir_q      <= 1'b0;
    end else begin
      resolved_q <= resolved_d;
      dir_q      <= dir_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/lbp_range_decoder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : lbp_range_decoder                                             |
// | Brief  : Receive-side LBP decoder. Rebuilds max/min from the triple   |
// |          {lbp1, lbp2, x}, resolves range membership MSB first (index  |
// |          0 is the MSB), clamps x and counts faulty results.           |
// | Ports  : clk, rst_n                  - clock, async active-low reset   |
// |          in_valid/in_ready           - triple handshake               |
// |          lbp1, lbp2, x_in            - protected triple               |
// |          out_valid/out_ready         - result handshake               |
// |          data_out, flag_hi/lo/inv    - clamped value and fault flags  |
// |          clr_cnt, fault_cnt          - saturating fault counter       |
// | Rev    : 1.0 - initial release                                         |
// +------------------------------------------------------------------------+
module lbp_range_decoder
  import odpc_pkg::*;
#(
  parameter int WIDTH = LBP_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:WIDTH-1] lbp1,
  input  logic [0:WIDTH-1] lbp2,
  input  logic [0:WIDTH-1] x_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:WIDTH-1] data_out,
  output logic             flag_hi,
  output logic             flag_lo,
  output logic             flag_inv,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] fault_cnt
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [0:WIDTH-1]    lbp1_q, lbp1_d;
  logic [0:WIDTH-1]    lbp2_q, lbp2_d;
  logic [0:WIDTH-1]    x_q, x_d;
  logic [0:WIDTH-1]    max_q, max_d;
  logic [0:WIDTH-1]    min_q, min_d;
  logic                inv_q, inv_d;
  logic [0:WIDTH-1]    data_out_q, data_out_d;
  logic [FLAG_W-1:0]   flags_q, flags_d;
  logic [CNT_W-1:0]    fault_cnt_q, fault_cnt_d;

  logic accept;
  logic scan_en;
  logic hi_resolved, hi_dir;
  logic lo_resolved, lo_dir;

  assign accept  = (state_q == IDLE) && in_valid;
  assign scan_en = (state_q == SCAN);

  lbp_bit_resolver #(.INVERT(1'b0)) u_hi_res (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (accept),
    .scan_en  (scan_en),
    .lbp_bit  (lbp1_q[idx_q]),
    .x_bit    (x_q[idx_q]),
    .resolved (hi_resolved),
    .dir      (hi_dir)
  );

  lbp_bit_resolver #(.INVERT(1'b1)) u_lo_res (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (accept),
    .scan_en  (scan_en),
    .lbp_bit  (lbp2_q[idx_q]),
    .x_bit    (x_q[idx_q]),
    .resolved (lo_resolved),
    .dir      (lo_dir)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    lbp1_d      = lbp1_q;
    lbp2_d      = lbp2_q;
    x_d         = x_q;
    max_d       = max_q;
    min_d       = min_q;
    inv_d       = inv_q;
    data_out_d  = data_out_q;
    flags_d     = flags_q;
    fault_cnt_d = fault_cnt_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          lbp1_d  = lbp1;
          lbp2_d  = lbp2;
          x_d     = x_in;
          max_d   = x_in ^ lbp1;
          min_d   = x_in ^ lbp2;
          inv_d   = (x_in ^ lbp2) > (x_in ^ lbp1);
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if ((hi_resolved && lo_resolved) || (idx_q == IDX_LAST)) begin
          state_d = DONE;
          flags_d = '0;
          // A still-unresolved bound equals x, so its dir stays 0
          if (inv_q) begin
            flags_d[FLAG_INV_BIT] = 1'b1;
            data_out_d            = min_q;
          end else if (hi_dir) begin
            flags_d[FLAG_HI_BIT]  = 1'b1;
            data_out_d            = max_q;
          end else if (lo_dir) begin
            flags_d[FLAG_LO_BIT]  = 1'b1;
            data_out_d            = min_q;
          end else begin
            data_out_d            = x_q;
          end
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          if ((|flags_q) && (fault_cnt_q != '1)) begin
            fault_cnt_d = fault_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (clr_cnt) begin
      fault_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      lbp1_q      <= '0;
      lbp2_q      <= '0;
      x_q         <= '0;
      max_q       <= '0;
      min_q       <= '0;
      inv_q       <= 1'b0;
      data_out_q  <= '0;
      flags_q     <= '0;
      fault_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      lbp1_q      <= lbp1_d;
      lbp2_q      <= lbp2_d;
      x_q         <= x_d;
      max_q       <= max_d;
      min_q       <= min_d;
      inv_q       <= inv_d;
      data_out_q  <= data_out_d;
      flags_q     <= flags_d;
      fault_cnt_q <= fault_cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign data_out  = data_out_q;
  assign flag_hi   = flags_q[FLAG_HI_BIT];
  assign flag_lo   = flags_q[FLAG_LO_BIT];
  assign flag_inv  = flags_q[FLAG_INV_BIT];
  assign fault_cnt = fault_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_lbp_range_decoder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : tb_lbp_range_decoder                                          |
// | Brief  : Self-checking bench for lbp_range_decoder. Two instances     |
// |          share stimulus: default counter width and a 2-bit counter.   |
// |          Expected results come from a numeric range-compare model.    |
// | Rev    : 1.0 - initial release                                         |
// +------------------------------------------------------------------------+
module tb_lbp_range_decoder;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         in_valid;
  logic         out_ready;
  logic         clr_cnt;
  logic [0:W-1] lbp1, lbp2, x_in;

  logic         in_ready_a, out_valid_a, flag_hi_a, flag_lo_a, flag_inv_a;
  logic [0:W-1] data_out_a;
  logic [15:0]  fault_cnt_a;

  logic         in_ready_b, out_valid_b, flag_hi_b, flag_lo_b, flag_inv_b;
  logic [0:W-1] data_out_b;
  logic [1:0]   fault_cnt_b;

  int n_vec = 0;
  int n_err = 0;
  int cnt_a_m = 0;
  int cnt_b_m = 0;

  lbp_range_decoder #(.WIDTH(W), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .lbp1(lbp1), .lbp2(lbp2), .x_in(x_in), .out_valid(out_valid_a),
    .out_ready(out_ready), .data_out(data_out_a), .flag_hi(flag_hi_a),
    .flag_lo(flag_lo_a), .flag_inv(flag_inv_a), .clr_cnt(clr_cnt),
    .fault_cnt(fault_cnt_a)
  );

  lbp_range_decoder #(.WIDTH(W), .CNT_W(2)) dut_c2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .lbp1(lbp1), .lbp2(lbp2), .x_in(x_in), .out_valid(out_valid_b),
    .out_ready(out_ready), .data_out(data_out_b), .flag_hi(flag_hi_b),
    .flag_lo(flag_lo_b), .flag_inv(flag_inv_b), .clr_cnt(clr_cnt),
    .fault_cnt(fault_cnt_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Position of the first set bit counted from the MSB; all-zero scans to the end
  function automatic int lead(input int v);
    if (v == 0) return W - 1;
    return W - $clog2(v + 1);
  endfunction

  task automatic run_txn(input int x, input int mx, input int mn, input int bp, input bit clr);
    int l1, l2, j, n, exp_data;
    bit e_hi, e_lo, e_inv;
    l1 = (x ^ mx) & 8'hFF;
    l2 = (x ^ mn) & 8'hFF;
    e_hi = 0; e_lo = 0; e_inv = 0;
    if (mn > mx)     begin e_inv = 1; exp_data = mn; end
    else if (x > mx) begin e_hi  = 1; exp_data = mx; end
    else if (x < mn) begin e_lo  = 1; exp_data = mn; end
    else             exp_data = x;
    j = (lead(l1) > lead(l2)) ? lead(l1) : lead(l2);

    n = 0;
    while (!in_ready_a && n < 50) begin @(posedge clk); #1; n++; end
    check("in_ready_idle", in_ready_a, 1);
    x_in = x; lbp1 = l1; lbp2 = l2; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    x_in = $urandom; lbp1 = $urandom; lbp2 = $urandom;
    check("in_ready_busy", in_ready_a, 0);

    n = 0;
    while (!out_valid_a && n < 40) begin @(posedge clk); #1; n++; end
    check("latency", n, j + 1);
    check("data_out", data_out_a, exp_data);
    check("flag_hi", flag_hi_a, e_hi);
    check("flag_lo", flag_lo_a, e_lo);
    check("flag_inv", flag_inv_a, e_inv);
    check("data_out_c2", data_out_b, exp_data);

    if (bp > 0) begin
      repeat (bp) begin @(posedge clk); #1; end
      check("hold_valid", out_valid_a, 1);
      check("hold_in_ready", in_ready_a, 0);
      check("hold_data", data_out_a, exp_data);
      check("hold_flags", {flag_inv_a, flag_hi_a, flag_lo_a}, {e_inv, e_hi, e_lo});
    end

    out_ready = 1; clr_cnt = clr;
    @(posedge clk); #1;
    out_ready = 0; clr_cnt = 0;
    if (clr) begin
      cnt_a_m = 0; cnt_b_m = 0;
    end else if (e_hi || e_lo || e_inv) begin
      if (cnt_a_m < 65535) cnt_a_m++;
      if (cnt_b_m < 3)     cnt_b_m++;
    end
    check("out_valid_drop", out_valid_a, 0);
    check("data_kept", data_out_a, exp_data);
    check("fault_cnt", fault_cnt_a, cnt_a_m);
    check("fault_cnt_c2", fault_cnt_b, cnt_b_m);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int x, a, b;
    rst_n = 0; in_valid = 0; out_ready = 0; clr_cnt = 0;
    lbp1 = '0; lbp2 = '0; x_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready_a, 1);
    check("rst_out_valid", out_valid_a, 0);
    check("rst_data", data_out_a, 0);
    check("rst_flags", {flag_inv_a, flag_hi_a, flag_lo_a}, 0);
    check("rst_cnt", fault_cnt_a, 0);
    rst_n = 1;
    @(posedge clk); #1;

    run_txn(8'h50, 8'h7F, 8'h10, 0, 0);  // in range
    run_txn(8'h90, 8'h7F, 8'h10, 0, 0);  // above max
    run_txn(8'h33, 8'h33, 8'h33, 0, 0);  // full scan
    run_txn(8'h40, 8'h10, 8'h80, 5, 0);  // inverted bounds, backpressure
    run_txn(8'h05, 8'hF0, 8'h20, 2, 0);  // below min
    run_txn(8'hFF, 8'hFE, 8'h00, 0, 0);  // above max, late decision
    run_txn(8'h00, 8'hFF, 8'h01, 1, 0);  // below min at LSB
    run_txn(8'hC0, 8'h80, 8'h00, 0, 1);  // faulty result with clear
    run_txn(8'h81, 8'h80, 8'h00, 0, 0);  // one fault after clear

    // Reset in the middle of a full-length scan
    x_in = 8'h33; lbp1 = 8'h00; lbp2 = 8'h00; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (3) begin @(posedge clk); #1; end
    #2 rst_n = 0;
    #1;
    cnt_a_m = 0; cnt_b_m = 0;
    check("midrst_out_valid", out_valid_a, 0);
    check("midrst_in_ready", in_ready_a, 1);
    check("midrst_cnt", fault_cnt_a, 0);
    check("midrst_cnt_c2", fault_cnt_b, 0);
    check("midrst_data", data_out_a, 0);
    #2 rst_n = 1;
    @(posedge clk); #1;

    for (int i = 0; i < 30; i++) begin
      x = $urandom_range(0, 255);
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      if ((i % 3) != 0 && a < b) run_txn(x, b, a, $urandom_range(0, 3), 0);
      else                       run_txn(x, a, b, $urandom_range(0, 3), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lbp_range_decoder.md
Name: lbp_range_decoder

Overview:
- Receive-side counterpart of the per-bit LBP comparator bank in the ODPC datapath.
- Consumes the protected triple {LBP1, LBP2, out_x}, where LBP1 = in_x XOR max and LBP2 = in_x XOR min.
- Reconstructs max and min, then resolves range membership bit-serially, MSB first (bit index 0 is the MSB).
- Emits a clamped value plus fault flags and a saturating fault counter to the CNN accelerator's fault monitor.

Parameters:
WIDTH, 8, data and LBP word width; bit 0 is the MSB
CNT_W, 16, width of the saturating fault counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input triple valid
in_ready  output  1  decoder can accept a triple
lbp1  input  [0:WIDTH-1]  in_x XOR max pattern
lbp2  input  [0:WIDTH-1]  in_x XOR min pattern
x_in  input  [0:WIDTH-1]  protected copy of in_x (comparator out_x)
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
data_out  output  [0:WIDTH-1]  range-clamped value
flag_hi  output  1  x above reconstructed max
flag_lo  output  1  x below reconstructed min
flag_inv  output  1  reconstructed min > max (corrupt bound pair)
clr_cnt  input  1  synchronous clear of fault_cnt
fault_cnt  output  CNT_W  saturating count of faulty results

Behaviour:
- Clocking and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: state IDLE, in_ready=1, out_valid=0, data_out=0, all flags=0, fault_cnt=0, bit index=0.
- Reset mid-operation: reset asserted in any state returns to these values immediately; the in-flight triple is discarded.
- FSM states: IDLE, SCAN, DONE. in_ready is 1 only in IDLE.
- IDLE:
  - On in_valid&&in_ready, register lbp1, lbp2 and x_in.
  - Register max_r=x_in^lbp1, min_r=x_in^lbp2 and inv = (min_r > max_r, unsigned).
  - Clear hi_res, lo_res and idx; go to SCAN.
- SCAN, one bit idx per cycle:
  - If hi unresolved and lbp1[idx]=1: hi_res=1, above_max=x[idx].
  - If lo unresolved and lbp2[idx]=1: lo_res=1, below_min=~x[idx].
  - Leave SCAN on the edge where both are resolved (counting this cycle) or idx==WIDTH-1; otherwise idx++.
- Unresolved at end of scan: x equals that bound, so the flag is 0.
- Latency: out_valid rises j+1 clock edges after the accept edge.
  - j = max(first set index of lbp1, first set index of lbp2).
  - If either pattern is all-zero, j = WIDTH-1.
- DONE, result registered on SCAN exit with priority inv > above_max > below_min:
  - inv: flag_inv=1, data_out=min_r.
  - above_max: flag_hi=1, data_out=max_r.
  - below_min: flag_lo=1, data_out=min_r.
  - Otherwise data_out=x.
  - Only one flag is ever high.
- Output handshake:
  - out_valid=1 in DONE; data_out and flags hold stable while out_ready=0.
  - On out_valid&&out_ready go to IDLE, with out_valid=0 next cycle.
  - data_out and flags keep their last value until the next result.
  - Minimum initiation interval is j+3 cycles.
- Fault counter:
  - Increments by 1 on each output handshake whose result has any flag set.
  - Saturates at all-ones; no wrap.
  - clr_cnt clears it next edge and has priority; an increment on the same edge is dropped.
- x_in, lbp1 and lbp2 are ignored outside the IDLE accept cycle.

Decomposition:
- Shared package odpc_pkg holds:
  - the FSM state typedef (IDLE/SCAN/DONE);
  - LBP_WIDTH=8;
  - flag bit positions for the fault-monitor bus.
- One sub-module, lbp_bit_resolver: per-bound single-bit resolve latch (lbp bit, x bit, resolved/dir registers), instantiated twice, once for max and once for min.
- FSM, clamp mux and counter stay in the top module.

Test Plan:
- In range: x=0x50, max=0x7F, min=0x10 (lbp1=0x2F, lbp2=0x40) -> j=2, out_valid 3 edges after accept, data_out=0x50, no flags, fault_cnt=0.
- Above max: x=0x90, max=0x7F, min=0x10 (lbp1=0xEF, lbp2=0x80) -> j=0, out_valid 1 edge after accept, data_out=0x7F, flag_hi=1, fault_cnt=1 after handshake.
- Full scan: x=max=min=0x33 (lbp1=lbp2=0x00) -> out_valid 8 edges after accept, data_out=0x33, no flags.
- Inverted bounds: x=0x40, max=0x10, min=0x80 (lbp1=0x50, lbp2=0xC0) -> flag_inv=1, data_out=0x80, flag_hi=0, flag_lo=0.
- Backpressure and reset: hold out_ready=0 for 5 cycles -> data_out/flags stable, in_ready=0. Separately, assert rst_n=0 mid-SCAN -> immediate out_valid=0, in_ready=1, fault_cnt=0.
- Counter: CNT_W=2 with 4 faulty results -> fault_cnt stays 3. clr_cnt on the same edge as a faulty handshake -> fault_cnt=0.
